// File: rtl/stream_arb_pkg.sv
// rtl/stream_arb_pkg.sv - shared types and round-robin winner search for stream_rr_arbiter
//   arb_state_e : output register occupancy (EMPTY / FULL)
//   rr_next     : first valid index after `last`, wrapping at `count`
package stream_arb_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Widest channel vector rr_next can search; callers zero-extend into it.
  localparam int MAX_CH  = 32;
  localparam int MAX_IDX = $clog2(MAX_CH);

  // Scans last+1, last+2, ... modulo count. Stepping with an explicit wrap
  // (rather than a modulo) keeps out-of-range indices unreachable for
  // non-power-of-two counts. Returns `last` when nothing is valid.
  function automatic int rr_next(input int last,
                                 input logic [MAX_CH-1:0] valid_vec,
                                 input int count);
    int   idx;
    int   win;
    logic found;
    idx   = last;
    win   = last;
    found = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      if (k < count) begin
        idx = (idx >= count - 1) ? 0 : idx + 1;
        if (!found && valid_vec[idx[MAX_IDX-1:0]]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// rtl/stream_rr_arbiter_if.sv - multi-channel input / single output valid-ready stream bundle
//   in_valid/in_data/in_ready : per-channel upstream handshake
//   out_valid/out_data/out_channel/out_ready : merged downstream handshake
//   slave  : arbiter view
//   master : producer/consumer view
interface stream_rr_arbiter_if #(
  parameter int CHANNELS_COUNT = 4,
  parameter int CHANNELS_WIDTH = 8
);
  localparam int IDX_W = $clog2(CHANNELS_COUNT);

  logic [CHANNELS_COUNT-1:0]                     in_valid;
  logic [CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0] in_data;
  logic [CHANNELS_COUNT-1:0]                     in_ready;
  logic                                          out_valid;
  logic [CHANNELS_WIDTH-1:0]                     out_data;
  logic [IDX_W-1:0]                              out_channel;
  logic                                          out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_channel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_channel
  );
endinterface

// File: rtl/mux_generic.sv
// rtl/mux_generic.sv - combinational N-way channel multiplexer
//   channels : packed per-channel data in
//   select   : channel index; out-of-range selects yield zero
//   data_out : selected channel data
module mux_generic #(
  parameter int CHANNELS_COUNT = 4,
  parameter int CHANNELS_WIDTH = 8,
  localparam int IDX_W = $clog2(CHANNELS_COUNT)
) (
  input  logic [CHANNELS_COUNT-1:0][CHANNELS_WIDTH-1:0] channels,
  input  logic [IDX_W-1:0]                              select,
  output logic [CHANNELS_WIDTH-1:0]                     data_out
);

  always_comb begin
    data_out = '0;
    for (int i = 0; i < CHANNELS_COUNT; i++) begin
      if (select == IDX_W'(i)) data_out = channels[i];
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// rtl/stream_rr_arbiter.sv - round-robin merge of N valid/ready streams into one registered stream
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : stream_rr_arbiter_if slave (in_* per channel, out_* merged output)
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int CHANNELS_COUNT = 4,
  parameter int CHANNELS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_rr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(CHANNELS_COUNT);

  if (CHANNELS_COUNT < 2) begin : g_bad_count
    $fatal(1, "stream_rr_arbiter: CHANNELS_COUNT must be >= 2");
  end
  if (CHANNELS_COUNT > MAX_CH) begin : g_too_many
    $fatal(1, "stream_rr_arbiter: CHANNELS_COUNT exceeds rr_next search width");
  end
  if (CHANNELS_WIDTH < 1) begin : g_bad_width
    $fatal(1, "stream_rr_arbiter: CHANNELS_WIDTH must be >= 1");
  end

  arb_state_e                state, state_nxt;
  logic [IDX_W-1:0]          last;
  logic [IDX_W-1:0]          winner;
  logic [CHANNELS_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]          channel_q;
  logic [CHANNELS_WIDTH-1:0] mux_data;
  logic [MAX_CH-1:0]         valid_ext;
  logic [CHANNELS_COUNT-1:0] ready_vec;
  logic                      load_en;
  logic                      accept;

  always_comb begin
    valid_ext                     = '0;
    valid_ext[CHANNELS_COUNT-1:0] = bus.in_valid;
    winner = IDX_W'(rr_next(int'(last), valid_ext, CHANNELS_COUNT));
  end

  // Gating with rst_n keeps every ready low while reset is held, so no
  // upstream handshake can complete against a register that is being cleared.
  assign load_en = (state == EMPTY) || bus.out_ready;
  assign accept  = rst_n && load_en && (|bus.in_valid);

  always_comb begin
    ready_vec = '0;
    if (accept) ready_vec[winner] = 1'b1;
  end

  mux_generic #(
    .CHANNELS_COUNT (CHANNELS_COUNT),
    .CHANNELS_WIDTH (CHANNELS_WIDTH)
  ) u_mux (
    .channels (bus.in_data),
    .select   (winner),
    .data_out (mux_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // A fresh accept wins over a drain so back-to-back words never bubble.
  always_comb begin
    state_nxt = state;
    if (accept)                                 state_nxt = FULL;
    else if (state == FULL && bus.out_ready)    state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      channel_q <= '0;
      last      <= IDX_W'(CHANNELS_COUNT - 1);
    end else if (accept) begin
      data_q    <= mux_data;
      channel_q <= winner;
      last      <= winner;
    end
  end

  assign bus.in_ready    = ready_vec;
  assign bus.out_valid   = (state == FULL);
  assign bus.out_data    = data_q;
  assign bus.out_channel = channel_q;

endmodule
